mul_seq: RTL and testbench

- Parametrised iterative multiplier and successor to the fixed-width combinational 8x8 multiplier.
- Multiplies two WIDTH-bit operands over WIDTH/DIGIT cycles, consuming DIGIT bits of b per cycle through one shared WIDTH x DIGIT partial-product unit.
- Adds a per-transaction signed/unsigned mode and valid/ready handshakes on both input and output.
- Sits in the functional-unit library as the low-area multiply for datapaths where multi-cycle latency is acceptable.

---
 rtl/mul_seq_pkg.sv | 33 +++
 rtl/mul_digit.sv | 15 +
 rtl/mul_seq.sv | 119 +++++++++++
 tb/tb_mul_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the iterative multiplier: FSM state encoding,
// step count and the signed-magnitude conversion applied to operands.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand abs_mag can handle; the top rejects larger WIDTH.
    localparam int MAX_W = 64;

    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    // |x| as an unsigned width-bit value when signed and negative, else x raw.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] x,
                                                 input int              width,
                                                 input logic            sgn);
        logic [MAX_W-1:0] mask;
        logic             neg;
        if (width >= MAX_W) begin
            mask = {MAX_W{1'b1}};
        end else begin
            mask = (MAX_W'(1) << width) - MAX_W'(1);
        end
        neg = sgn & x[width-1];
        return neg ? ((~x + MAX_W'(1)) & mask) : (x & mask);
    endfunction

endpackage

// File: rtl/mul_digit.sv
// Combinational WIDTH x DIGIT unsigned partial-product unit.
module mul_digit
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic [WIDTH-1:0]       i_a,
    input  logic [DIGIT-1:0]       i_d,
    output logic [WIDTH+DIGIT-1:0] o_p
);

    assign o_p = (WIDTH+DIGIT)'(i_a) * (WIDTH+DIGIT)'(i_d);

endmodule

// File: rtl/mul_seq.sv
// Iterative WIDTH x WIDTH multiplier retiring DIGIT bits of b per cycle,
// with per-transaction signed mode and valid/ready on both sides.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW    = 2 * WIDTH;

    if (((WIDTH % DIGIT) != 0) || (WIDTH > MAX_W)) begin : g_param_check
        $error("mul_seq: WIDTH must be a multiple of DIGIT and at most MAX_W");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_mag;
    logic [WIDTH-1:0]   r_b_mag;
    logic               r_neg;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_r;

    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [DIGIT-1:0]       w_digit;
    logic [WIDTH+DIGIT-1:0] w_pp;
    logic [PW-1:0]          w_pp_sh;
    logic [PW-1:0]          w_acc_next;
    logic                   w_last;

    assign w_a_mag    = WIDTH'(abs_mag(MAX_W'(a), WIDTH, is_signed));
    assign w_b_mag    = WIDTH'(abs_mag(MAX_W'(b), WIDTH, is_signed));
    assign w_digit    = r_b_mag[r_cnt*DIGIT +: DIGIT];
    assign w_pp_sh    = PW'(w_pp) << (r_cnt*DIGIT);
    assign w_acc_next = r_acc + w_pp_sh;
    assign w_last     = (r_cnt == CNT_W'(STEPS-1));

    mul_digit #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_mul_digit (
        .i_a (r_a_mag),
        .i_d (w_digit),
        .o_p (w_pp)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; in_ready is implied by IDLE so in_valid alone accepts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = BUSY; else w_state_next = IDLE;
            BUSY:    if (w_last)    w_state_next = DONE; else w_state_next = BUSY;
            DONE:    if (out_ready) w_state_next = IDLE; else w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, digit-serial accumulation and the result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_mag <= {WIDTH{1'b0}};
            r_b_mag <= {WIDTH{1'b0}};
            r_neg   <= 1'b0;
            r_acc   <= {PW{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_r     <= {PW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_mag <= w_a_mag;
                        r_b_mag <= w_b_mag;
                        r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc   <= {PW{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_r <= r_neg ? (-w_acc_next) : w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign r         = r_r;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq (WIDTH=16, DIGIT=4) against a plain
// arithmetic reference product.
module tb_mul_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;

    int errors;
    int checks;

    mul_seq #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
        longint px;
        longint py;
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'(x);
            py = longint'(y);
        end
        return 32'(px * py);
    endfunction

    // Accept one operation, return its result and edges from accept to out_valid.
    task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic os,
                          output logic [31:0] res, output int lat);
        int n;
        @(negedge clk);
        a = oa; b = ob; is_signed = os; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        res = r;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_r got=%h want=0", r); end
    endtask

    task automatic test_unsigned_max();
        logic [31:0] res;
        int lat;
        run_op(16'hFFFF, 16'hFFFF, 1'b0, res, lat);
        checks++; if (res !== 32'hFFFE0001) begin errors++; $display("FAIL umax_r got=%h want=fffe0001", res); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL umax_latency got=%0d want=4", lat); end
    endtask

    task automatic test_mode_contrast();
        logic [31:0] res;
        int lat;
        run_op(16'hFFFD, 16'h0007, 1'b1, res, lat);
        checks++; if (res !== 32'hFFFFFFEB) begin errors++; $display("FAIL mode_signed got=%h want=ffffffeb", res); end
        run_op(16'hFFFD, 16'h0007, 1'b0, res, lat);
        checks++; if (res !== 32'h0006FFEB) begin errors++; $display("FAIL mode_unsigned got=%h want=0006ffeb", res); end
    endtask

    task automatic test_most_negative();
        logic [31:0] res;
        int lat;
        run_op(16'h8000, 16'h8000, 1'b1, res, lat);
        checks++; if (res !== 32'h40000000) begin errors++; $display("FAIL mn_sq got=%h want=40000000", res); end
        run_op(16'h8000, 16'h0001, 1'b1, res, lat);
        checks++; if (res !== 32'hFFFF8000) begin errors++; $display("FAIL mn_one got=%h want=ffff8000", res); end
        run_op(16'h0000, 16'h8000, 1'b1, res, lat);
        checks++; if (res !== 32'h00000000) begin errors++; $display("FAIL mn_zero got=%h want=0", res); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL mn_zero_latency got=%0d want=4", lat); end
    endtask

    task automatic test_random();
        logic [31:0] res;
        logic [31:0] exp;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        int lat;
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            exp = ref_mul(ra, rb, rs);
            run_op(ra, rb, rs, res, lat);
            checks++; if (res !== exp) begin errors++; $display("FAIL random_%0d a=%h b=%h s=%b got=%h want=%h", i, ra, rb, rs, res, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [31:0] exp2;
        int n;
        @(negedge clk);
        a = 16'h1234; b = 16'h00AB; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        held = r;
        checks++; if (held !== ref_mul(16'h1234, 16'h00AB, 1'b0)) begin errors++; $display("FAIL bp_first got=%h want=%h", held, ref_mul(16'h1234, 16'h00AB, 1'b0)); end
        exp2 = ref_mul(16'hC001, 16'h7FFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 16'hC001; b = 16'h7FFF; is_signed = 1'b1; in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (r !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d r=%h want=%h ov=%b want=1 ir=%b want=0", i, r, held, out_valid, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b want=0", in_ready); end
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_second_latency got=%0d want=4", n); end
        checks++; if (r !== exp2) begin errors++; $display("FAIL bp_second_r got=%h want=%h", r, exp2); end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        int lat;
        @(negedge clk);
        a = 16'hABCD; b = 16'h1234; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL midrst_r got=%h want=0", r); end
        @(negedge clk);
        reset = 1'b0;
        run_op(16'd3, 16'd5, 1'b0, res, lat);
        checks++; if (res !== 32'd15) begin errors++; $display("FAIL midrst_fresh got=%0d want=15", res); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got=%0d want=4", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expq[$];
        logic [31:0] exp;
        int sent;
        int got;
        int last_cyc;
        int cyc;
        sent = 0; got = 0; last_cyc = -1;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 200 && got < 10; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                if (sent < 10) begin
                    a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
                    in_valid = 1'b1;
                    expq.push_back(ref_mul(a, b, is_signed));
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                exp = (expq.size() > 0) ? expq.pop_front() : 32'hDEADBEEF;
                checks++; if (r !== exp) begin errors++; $display("FAIL b2b_r_%0d got=%h want=%h", got, r, exp); end
                if (last_cyc >= 0) begin
                    checks++; if (cyc - last_cyc !== 6) begin errors++; $display("FAIL b2b_spacing_%0d got=%0d want=6", got, cyc - last_cyc); end
                end
                last_cyc = cyc;
                got++;
            end
        end
        checks++; if (got !== 10) begin errors++; $display("FAIL b2b_count got=%0d want=10", got); end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; is_signed = 1'b0;
        test_reset();
        test_unsigned_max();
        test_mode_contrast();
        test_most_negative();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
